// File: rtl/alu_issue_ctrl.sv
// alu_issue_ctrl: two-stage issue controller feeding the ALU and capturing its result/branch outcome
module alu_issue_ctrl #(
  parameter int SIZE = 32
) (
  input  logic            i_clk,
  input  logic            i_rst_n,
  input  logic            i_in_valid,
  output logic            o_in_ready,
  input  logic [6:0]      i_opcode,
  input  logic [2:0]      i_funct3,
  input  logic            i_funct7_5,
  input  logic [SIZE-1:0] i_rs1_val,
  input  logic [SIZE-1:0] i_rs2_val,
  input  logic [SIZE-1:0] i_imm,
  input  logic            i_flush,
  output logic [SIZE-1:0] o_x,
  output logic [SIZE-1:0] o_y,
  output logic [3:0]      o_control,
  input  logic [SIZE-1:0] i_resultado,
  input  logic            i_zero,
  output logic            o_out_valid,
  input  logic            i_out_ready,
  output logic [SIZE-1:0] o_out_result,
  output logic            o_out_branch,
  output logic            o_out_taken,
  output logic            o_out_illegal
);
  localparam logic [6:0] OPC_OP  = 7'b0110011;
  localparam logic [6:0] OPC_IMM = 7'b0010011;
  localparam logic [6:0] OPC_BR  = 7'b1100011;
  localparam logic [3:0] C_ADD  = 4'b0000;
  localparam logic [3:0] C_OR   = 4'b0001;
  localparam logic [3:0] C_AND  = 4'b0010;
  localparam logic [3:0] C_SLT  = 4'b0100;
  localparam logic [3:0] C_SUB  = 4'b0111;
  localparam logic [3:0] C_SLL  = 4'b1000;
  localparam logic [3:0] C_XOR  = 4'b1001;
  localparam logic [3:0] C_SRL  = 4'b1010;
  localparam logic [3:0] C_SLTU = 4'b1101;
  localparam logic [3:0] C_SRA  = 4'b1110;

  logic            w_is_op, w_is_imm, w_is_br, w_br_ok, w_shift;
  logic [3:0]      w_f3_code, w_ctrl;
  logic [SIZE-1:0] w_x, w_y;
  logic            w_ill, w_br;
  logic            w_adv2, w_ld1, w_accept, w_cond;

  logic            r_s1_valid, r_s1_br, r_s1_ill;
  logic [2:0]      r_s1_kind;
  logic            r_s2_valid;

  assign w_is_op  = i_opcode == OPC_OP;
  assign w_is_imm = i_opcode == OPC_IMM;
  assign w_is_br  = i_opcode == OPC_BR;
  assign w_br_ok  = i_funct3[2:1] != 2'b01;
  assign w_shift  = i_funct3[1:0] == 2'b01;

  // Stage 2 drains when empty or when downstream takes its entry; stage 1 loads when it can move on.
  assign w_adv2     = !r_s2_valid | i_out_ready;
  assign w_ld1      = !r_s1_valid | w_adv2;
  assign o_in_ready = i_rst_n & !i_flush & w_ld1;
  assign w_accept   = i_in_valid & o_in_ready;
  assign o_out_valid = r_s2_valid;

  // Shared funct3 map for OP and OP-IMM; funct7[5] selects SUB only for register-register ops.
  always_comb begin
    case (i_funct3)
      3'd0:    w_f3_code = (w_is_op & i_funct7_5) ? C_SUB : C_ADD;
      3'd1:    w_f3_code = C_SLL;
      3'd2:    w_f3_code = C_SLT;
      3'd3:    w_f3_code = C_SLTU;
      3'd4:    w_f3_code = C_XOR;
      3'd5:    w_f3_code = i_funct7_5 ? C_SRA : C_SRL;
      3'd6:    w_f3_code = C_OR;
      default: w_f3_code = C_AND;
    endcase
  end

  // Operand selection and control decode; illegal encodings issue ADD 0,0.
  always_comb begin
    w_ctrl = C_ADD;
    w_x    = '0;
    w_y    = '0;
    w_ill  = 1'b0;
    w_br   = 1'b0;
    if (w_is_op | w_is_imm) begin
      w_ctrl = w_f3_code;
      w_x    = i_rs1_val;
      w_y    = w_is_op ? i_rs2_val : (w_shift ? {{(SIZE-5){1'b0}}, i_imm[4:0]} : i_imm);
    end else if (w_is_br & w_br_ok) begin
      w_br   = 1'b1;
      w_x    = i_rs1_val;
      w_y    = i_rs2_val;
      w_ctrl = i_funct3[2] ? (i_funct3[1] ? C_SLTU : C_SLT) : C_SUB;
    end else begin
      w_ill  = 1'b1;
    end
  end

  // Even kinds test the condition directly, odd kinds its inverse (BNE/BGE/BGEU).
  assign w_cond = (r_s1_kind[2] ? i_resultado[0] : i_zero) ^ r_s1_kind[0];

  // Stage 1: ALU operand/control register.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_s1_valid <= 1'b0;
      o_x        <= '0;
      o_y        <= '0;
      o_control  <= C_ADD;
      r_s1_kind  <= '0;
      r_s1_br    <= 1'b0;
      r_s1_ill   <= 1'b0;
    end else if (i_flush) begin
      r_s1_valid <= 1'b0;
    end else if (w_ld1) begin
      r_s1_valid <= w_accept;
      if (w_accept) begin
        o_x       <= w_x;
        o_y       <= w_y;
        o_control <= w_ctrl;
        r_s1_kind <= i_funct3;
        r_s1_br   <= w_br;
        r_s1_ill  <= w_ill;
      end
    end
  end

  // Stage 2: capture ALU result and resolve the branch.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_s2_valid    <= 1'b0;
      o_out_result  <= '0;
      o_out_branch  <= 1'b0;
      o_out_taken   <= 1'b0;
      o_out_illegal <= 1'b0;
    end else if (i_flush) begin
      r_s2_valid <= 1'b0;
    end else if (w_adv2) begin
      r_s2_valid <= r_s1_valid;
      if (r_s1_valid) begin
        o_out_result  <= r_s1_ill ? '0 : i_resultado;
        o_out_branch  <= r_s1_br;
        o_out_taken   <= r_s1_br & w_cond;
        o_out_illegal <= r_s1_ill;
      end
    end
  end
endmodule

// File: tb/tb_alu_issue_ctrl.sv
// tb_alu_issue_ctrl: directed scoreboard bench for alu_issue_ctrl with a behavioural ALU
module tb_alu_issue_ctrl;
  localparam logic [6:0] OP = 7'b0110011, OPI = 7'b0010011, BR = 7'b1100011, LD = 7'b0000011;

  typedef struct packed {
    logic        ill;
    logic        br;
    logic        tk;
    logic [31:0] res;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        i_in_valid = 1'b0;
  logic        o_in_ready;
  logic [6:0]  i_opcode = '0;
  logic [2:0]  i_funct3 = '0;
  logic        i_funct7_5 = 1'b0;
  logic [31:0] i_rs1_val = '0, i_rs2_val = '0, i_imm = '0;
  logic        i_flush = 1'b0;
  logic [31:0] o_x, o_y;
  logic [3:0]  o_control;
  logic [31:0] alu_res;
  logic        alu_zero;
  logic        o_out_valid;
  logic        i_out_ready = 1'b1;
  logic [31:0] o_out_result;
  logic        o_out_branch, o_out_taken, o_out_illegal;

  int   n_cmp = 0;
  int   n_bad = 0;
  exp_t q[$];

  alu_issue_ctrl #(.SIZE(32)) dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_in_valid(i_in_valid), .o_in_ready(o_in_ready),
    .i_opcode(i_opcode), .i_funct3(i_funct3), .i_funct7_5(i_funct7_5),
    .i_rs1_val(i_rs1_val), .i_rs2_val(i_rs2_val), .i_imm(i_imm), .i_flush(i_flush),
    .o_x(o_x), .o_y(o_y), .o_control(o_control), .i_resultado(alu_res), .i_zero(alu_zero),
    .o_out_valid(o_out_valid), .i_out_ready(i_out_ready), .o_out_result(o_out_result),
    .o_out_branch(o_out_branch), .o_out_taken(o_out_taken), .o_out_illegal(o_out_illegal)
  );

  always #5 clk = ~clk;

  // Behavioural combinational ALU answering the DUT's X/Y/CONTROL.
  always_comb begin
    case (o_control)
      4'b0000: alu_res = o_x + o_y;
      4'b0001: alu_res = o_x | o_y;
      4'b0010: alu_res = o_x & o_y;
      4'b0100: alu_res = {31'b0, $signed(o_x) < $signed(o_y)};
      4'b0111: alu_res = o_x - o_y;
      4'b1000: alu_res = o_x << o_y[4:0];
      4'b1001: alu_res = o_x ^ o_y;
      4'b1010: alu_res = o_x >> o_y[4:0];
      4'b1101: alu_res = {31'b0, o_x < o_y};
      4'b1110: alu_res = $signed(o_x) >>> o_y[4:0];
      default: alu_res = '0;
    endcase
    alu_zero = alu_res == '0;
  end

  // Instruction-level reference model, independent of the ALU control encoding.
  function automatic exp_t model(input logic [6:0] op, input logic [2:0] f3, input logic f7,
                                 input logic [31:0] a, input logic [31:0] b, input logic [31:0] imm);
    exp_t e;
    logic [31:0] y;
    e = '0;
    if (op == OP || op == OPI) begin
      y = (op == OP) ? b : imm;
      case (f3)
        3'd0: e.res = (op == OP && f7) ? a - y : a + y;
        3'd1: e.res = a << y[4:0];
        3'd2: e.res = {31'b0, $signed(a) < $signed(y)};
        3'd3: e.res = {31'b0, a < y};
        3'd4: e.res = a ^ y;
        3'd5: e.res = f7 ? 32'($signed(a) >>> y[4:0]) : a >> y[4:0];
        3'd6: e.res = a | y;
        default: e.res = a & y;
      endcase
    end else if (op == BR && f3 != 3'd2 && f3 != 3'd3) begin
      e.br = 1'b1;
      case (f3)
        3'd0: begin e.res = a - b; e.tk = a == b; end
        3'd1: begin e.res = a - b; e.tk = a != b; end
        3'd4: begin e.res = {31'b0, $signed(a) < $signed(b)}; e.tk = $signed(a) < $signed(b); end
        3'd5: begin e.res = {31'b0, $signed(a) < $signed(b)}; e.tk = !($signed(a) < $signed(b)); end
        3'd6: begin e.res = {31'b0, a < b}; e.tk = a < b; end
        default: begin e.res = {31'b0, a < b}; e.tk = !(a < b); end
      endcase
    end else begin
      e.ill = 1'b1;
    end
    return e;
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // One clock: retire any output transfer against the scoreboard, log any accept, advance.
  task automatic tick();
    exp_t e;
    #1;
    if (o_out_valid && i_out_ready) begin
      if (q.size() == 0) chk("sb_unexpected_out", 64'(o_out_valid), 64'(0));
      else begin
        e = q.pop_front();
        chk("sb_result", 64'(o_out_result), 64'(e.res));
        chk("sb_flags", {61'b0, o_out_illegal, o_out_branch, o_out_taken}, {61'b0, e.ill, e.br, e.tk});
      end
    end
    if (i_in_valid && o_in_ready)
      q.push_back(model(i_opcode, i_funct3, i_funct7_5, i_rs1_val, i_rs2_val, i_imm));
    @(posedge clk);
    #1;
  endtask

  task automatic set_in(input logic [6:0] op, input logic [2:0] f3, input logic f7,
                        input logic [31:0] a, input logic [31:0] b, input logic [31:0] imm);
    i_opcode = op; i_funct3 = f3; i_funct7_5 = f7;
    i_rs1_val = a; i_rs2_val = b; i_imm = imm;
    i_in_valid = 1'b1;
    #1;
  endtask

  task automatic issue(input logic [6:0] op, input logic [2:0] f3, input logic f7,
                       input logic [31:0] a, input logic [31:0] b, input logic [31:0] imm);
    set_in(op, f3, f7, a, b, imm);
    tick();
    i_in_valid = 1'b0;
  endtask

  initial begin
    int  n;
    logic acc;
    logic [2:0]  br_f3 [4] = '{3'd0, 3'd1, 3'd5, 3'd6};
    logic [31:0] br_a  [4] = '{32'd4, 32'd4, 32'd5, 32'hFFFFFFFF};
    logic [31:0] br_b  [4] = '{32'd4, 32'd4, 32'd3, 32'd1};
    logic        br_tk [4] = '{1'b1, 1'b0, 1'b1, 1'b0};
    exp_t e;

    repeat (2) @(posedge clk);
    #1;
    chk("rst_in_ready", 64'(o_in_ready), 64'(0));
    chk("rst_xy", {o_x, o_y}, 64'(0));
    chk("rst_control", 64'(o_control), 64'(0));
    chk("rst_outs", {o_out_result, 28'b0, o_out_valid, o_out_branch, o_out_taken, o_out_illegal}, 64'(0));
    rst_n = 1'b1;
    #1;
    chk("post_rst_in_ready", 64'(o_in_ready), 64'(1));

    issue(OPI, 3'd0, 1'b0, 32'd19, 32'd0, 32'd2);
    chk("addi_ctrl", 64'(o_control), 64'(4'b0000));
    chk("addi_xy", {o_x, o_y}, {32'd19, 32'd2});
    tick();
    chk("addi_valid", 64'(o_out_valid), 64'(1));
    chk("addi_result", 64'(o_out_result), 64'(21));
    tick();

    issue(OP, 3'd0, 1'b1, 32'd22, 32'd5, 32'd0);
    chk("sub_ctrl", 64'(o_control), 64'(4'b0111));
    issue(OPI, 3'd5, 1'b1, 32'hFFFFFFF8, 32'd0, 32'h402);
    chk("srai_ctrl", 64'(o_control), 64'(4'b1110));
    chk("srai_y", 64'(o_y), 64'(2));
    chk("sub_result", 64'(o_out_result), 64'(17));
    tick();
    chk("srai_result", 64'(o_out_result), 64'(32'hFFFFFFFE));
    tick();

    for (int i = 0; i < 4; i++) begin
      issue(BR, br_f3[i], 1'b0, br_a[i], br_b[i], 32'd0);
      tick();
      chk("br_branch", 64'(o_out_branch), 64'(1));
      chk("br_taken", 64'(o_out_taken), 64'(br_tk[i]));
    end
    tick();

    n = 0;
    i_out_ready = 1'b0;
    for (int c = 0; c < 3; c++) begin
      set_in(OP, 3'd0, 1'b0, 32'(10 * n + 1), 32'(n + 100), 32'd0);
      if (c == 2) chk("bp_in_ready_low", 64'(o_in_ready), 64'(0));
      acc = o_in_ready;
      tick();
      if (acc) n++;
    end
    chk("bp_accepts", 64'(n), 64'(2));
    chk("bp_hold_valid", 64'(o_out_valid), 64'(1));
    chk("bp_hold_result", 64'(o_out_result), 64'(101));
    chk("bp_hold_x", 64'(o_x), 64'(11));
    i_out_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      if (n < 4) set_in(OP, 3'd0, 1'b0, 32'(10 * n + 1), 32'(n + 100), 32'd0);
      else begin i_in_valid = 1'b0; #1; end
      chk("stream_valid", 64'(o_out_valid), 64'(1));
      acc = i_in_valid && o_in_ready;
      tick();
      if (acc) n++;
    end
    i_in_valid = 1'b0;
    chk("stream_done", {32'(n), 31'b0, o_out_valid}, {32'd4, 32'd0});

    i_out_ready = 1'b0;
    issue(OP, 3'd6, 1'b0, 32'hF0, 32'h0F, 32'd0);
    issue(OP, 3'd4, 1'b0, 32'hFF, 32'h0F, 32'd0);
    set_in(OP, 3'd0, 1'b0, 32'd7, 32'd7, 32'd0);
    i_flush = 1'b1;
    #1;
    chk("flush_in_ready", 64'(o_in_ready), 64'(0));
    tick();
    i_flush = 1'b0;
    i_in_valid = 1'b0;
    q.delete();
    chk("flush_valid", 64'(o_out_valid), 64'(0));
    i_out_ready = 1'b1;
    tick();
    chk("flush_no_stale", 64'(o_out_valid), 64'(0));

    issue(LD, 3'd2, 1'b0, 32'd5, 32'd6, 32'd7);
    chk("ill_issue", {o_x, o_y}, 64'(0));
    chk("ill_ctrl", 64'(o_control), 64'(0));
    issue(BR, 3'd2, 1'b0, 32'd4, 32'd4, 32'd0);
    chk("ill_ld", {o_out_result, 29'b0, o_out_valid, o_out_illegal, o_out_taken}, {32'd0, 32'b110});
    tick();
    e = model(BR, 3'd2, 1'b0, 32'd4, 32'd4, 32'd0);
    chk("ill_br_model", 64'(e.ill), 64'(1));
    chk("ill_br", {o_out_result, 29'b0, o_out_valid, o_out_illegal, o_out_taken}, {32'd0, 32'b110});
    tick();

    issue(OP, 3'd0, 1'b0, 32'd1, 32'd2, 32'd0);
    issue(OP, 3'd0, 1'b0, 32'd3, 32'd4, 32'd0);
    chk("arst_pre_valid", 64'(o_out_valid), 64'(1));
    #2 rst_n = 1'b0;
    #1;
    chk("arst_valid", 64'(o_out_valid), 64'(0));
    chk("arst_in_ready", 64'(o_in_ready), 64'(0));
    q.delete();
    #2 rst_n = 1'b1;
    tick();
    chk("arst_after", 64'(o_out_valid), 64'(0));
    chk("sb_empty", 64'(q.size()), 64'(0));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
